// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between a PS/2 transmit client and ps2_host_tx.
// The client drives the byte and request; the transmitter drives status and result pulses.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    logic [1:0] err_code;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_busy, tx_done, tx_err, err_code
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_busy, tx_done, tx_err, err_code
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter driving open-drain clock/data through pull-low enables.
// Optional macro PS2_TX_RETRY_EN: up to two automatic retries of a failed transfer.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 4
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave host,
    input  logic         ps2_clk_i,
    input  logic         ps2_data_i,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);
    localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int FW = $clog2(FILTER_LEN) + 1;
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, SEND, WAIT_ACK, WAIT_IDLE} state_t;

    // Index 0 is the clock line, index 1 the data line.
    logic [1:0] pin_raw;
    logic [1:0] pin_filt;
    assign pin_raw = {ps2_data_i, ps2_clk_i};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cond
            logic          s1_reg, s2_reg, filt_reg;
            logic [FW-1:0] cnt_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s1_reg   <= 1'b1;
                    s2_reg   <= 1'b1;
                    filt_reg <= 1'b1;
                    cnt_reg  <= '0;
                end else begin
                    s1_reg <= pin_raw[gi];
                    s2_reg <= s1_reg;
                    if (s2_reg == filt_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == FW'(FILTER_LEN - 1)) begin
                        filt_reg <= s2_reg;
                        cnt_reg  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end
            assign pin_filt[gi] = filt_reg;
        end
    endgenerate

    logic clk_filt_d_reg;
    logic clk_fall;
    assign clk_fall = clk_filt_d_reg & ~pin_filt[0];

    state_t        state_reg, state_next;
    logic [7:0]    data_reg, data_next;
    logic [8:0]    shift_reg, shift_next;
    logic [3:0]    bit_cnt_reg, bit_cnt_next;
    logic [IW-1:0] inh_cnt_reg, inh_cnt_next;
    logic [TW-1:0] to_cnt_reg, to_cnt_next;
    logic          data_oe_reg, data_oe_next;
    logic [1:0]    err_code_reg, err_code_next;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]    retry_reg, retry_next;
`endif
    logic          done, err, fail, inhibit_last;
    logic [1:0]    fail_code;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            data_reg       <= '0;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            inh_cnt_reg    <= '0;
            to_cnt_reg     <= '0;
            data_oe_reg    <= 1'b0;
            err_code_reg   <= 2'b00;
            clk_filt_d_reg <= 1'b1;
`ifdef PS2_TX_RETRY_EN
            retry_reg      <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            data_reg       <= data_next;
            shift_reg      <= shift_next;
            bit_cnt_reg    <= bit_cnt_next;
            inh_cnt_reg    <= inh_cnt_next;
            to_cnt_reg     <= to_cnt_next;
            data_oe_reg    <= data_oe_next;
            err_code_reg   <= err_code_next;
            clk_filt_d_reg <= pin_filt[0];
`ifdef PS2_TX_RETRY_EN
            retry_reg      <= retry_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        data_next     = data_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        inh_cnt_next  = inh_cnt_reg;
        to_cnt_next   = to_cnt_reg;
        data_oe_next  = data_oe_reg;
        err_code_next = err_code_reg;
`ifdef PS2_TX_RETRY_EN
        retry_next    = retry_reg;
`endif
        done          = 1'b0;
        err           = 1'b0;
        fail          = 1'b0;
        fail_code     = 2'b00;
        inhibit_last  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (host.tx_valid) begin
                    data_next    = host.tx_data;
                    inh_cnt_next = '0;
`ifdef PS2_TX_RETRY_EN
                    retry_next   = '0;
`endif
                    state_next   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt_reg == INH_LAST) begin
                    inhibit_last = 1'b1;
                    data_oe_next = 1'b1;
                    shift_next   = {~^data_reg, data_reg};
                    bit_cnt_next = '0;
                    to_cnt_next  = '0;
                    state_next   = SEND;
                end else begin
                    inh_cnt_next = inh_cnt_reg + 1'b1;
                end
            end
            SEND: begin
                if (to_cnt_reg == TO_LAST) begin
                    fail      = 1'b1;
                    fail_code = 2'b01;
                end else if (clk_fall) begin
                    to_cnt_next  = '0;
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == 4'd9) begin
                        data_oe_next = 1'b0;
                        state_next   = WAIT_ACK;
                    end else begin
                        data_oe_next = ~shift_reg[0];
                        shift_next   = {1'b0, shift_reg[8:1]};
                    end
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end
            WAIT_ACK: begin
                if (to_cnt_reg == TO_LAST) begin
                    fail      = 1'b1;
                    fail_code = 2'b01;
                end else if (clk_fall) begin
                    to_cnt_next = '0;
                    if (!pin_filt[1]) begin
                        state_next = WAIT_IDLE;
                    end else begin
                        fail      = 1'b1;
                        fail_code = 2'b10;
                    end
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (to_cnt_reg == TO_LAST) begin
                    fail      = 1'b1;
                    fail_code = 2'b01;
                end else if (pin_filt == 2'b11) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Any abort releases data; the clock is already released outside INHIBIT.
        if (fail) begin
            data_oe_next = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (retry_reg != 2'd2) begin
                retry_next   = retry_reg + 1'b1;
                inh_cnt_next = '0;
                state_next   = INHIBIT;
            end else begin
                err           = 1'b1;
                err_code_next = fail_code;
                state_next    = IDLE;
            end
`else
            err           = 1'b1;
            err_code_next = fail_code;
            state_next    = IDLE;
`endif
        end
    end

    assign ps2_clk_oe    = (state_reg == INHIBIT);
    assign ps2_data_oe   = (data_oe_reg & ~fail) | inhibit_last;
    assign host.tx_ready = (state_reg == IDLE);
    assign host.tx_busy  = (state_reg != IDLE);
    assign host.tx_done  = done;
    assign host.tx_err   = err;
    assign host.err_code = err ? fail_code : err_code_reg;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model and shortened timing.
module tb_ps2_host_tx;
    localparam int INH = 50;
    localparam int TO  = 2000;
    localparam int FL  = 4;
    localparam int H   = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ps2_clk_oe, ps2_data_oe;
    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic ps2_clk_i, ps2_data_i;

    ps2_host_tx_if bus();

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
        .clk         (clk),
        .rst         (rst),
        .host        (bus),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int inh_run = 0, inh_len = 0, inh_phases = 0;
    logic [1:0] last_err_code = 2'b00;

    always @(negedge clk) begin
        if (rst) begin
            if (bus.tx_done) done_cnt++;
            if (bus.tx_err) begin
                err_cnt++;
                last_err_code = bus.err_code;
            end
            if (bus.tx_done && bus.tx_err) both_cnt++;
            if (ps2_clk_oe) begin
                inh_run++;
            end else if (inh_run != 0) begin
                inh_len = inh_run;
                inh_run = 0;
                inh_phases++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vec %0d %s obs=%0h exp=%0h", n_vec, tag, obs, exp);
    endtask

    task automatic send_req(input logic [7:0] b);
        @(negedge clk);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int t;
        t = 0;
        while (!bus.tx_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!bus.tx_ready) chk(tag, 32'(bus.tx_ready), 32'd1);
    endtask

    // Device side of one frame: waits out the inhibit, then produces `edges` clock pulses,
    // sampling the data line on each rising edge. Edge 11 is the ACK slot.
    task automatic dev_frame(input int edges, input bit ack, input bit glitch,
                             output logic [9:0] bits, output logic start);
        int t;
        logic oe_before;
        bits  = '1;
        start = 1'b1;
        t = 0;
        while (!ps2_clk_oe && t < 200) begin @(negedge clk); t++; end
        t = 0;
        while (ps2_clk_oe && t < INH + 20) begin @(negedge clk); t++; end
        start = ps2_data_i;
        repeat (10) @(negedge clk);
        for (int i = 0; i < edges && i < 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            bits[i] = ps2_data_i;
            if (glitch && i == 3) begin
                repeat (5) @(negedge clk);
                oe_before = ps2_data_oe;
                dev_clk_low = 1'b1;
                repeat (2) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (12) @(negedge clk);
                chk("glitch_no_advance", 32'(ps2_data_oe), 32'(oe_before));
                repeat (1) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
        end
        if (edges == 11) begin
            if (ack) dev_data_low = 1'b1;
            repeat (4) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (H) @(negedge clk);
            dev_data_low = 1'b0;
        end
    endtask

    logic [9:0] bits;
    logic       start;
    int         d0, e0, p0, n;
    logic [7:0] pbyte [3];
    logic       ppar  [3];

    initial begin
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        pbyte[0] = 8'h07; ppar[0] = 1'b0;
        pbyte[1] = 8'hFF; ppar[1] = 1'b1;
        pbyte[2] = 8'h00; ppar[2] = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        chk("rst_ready", 32'(bus.tx_ready), 32'd1);
        chk("rst_busy", 32'(bus.tx_busy), 32'd0);
        chk("rst_done", 32'(bus.tx_done), 32'd0);
        chk("rst_err", 32'(bus.tx_err), 32'd0);
        chk("rst_err_code", 32'(bus.err_code), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 0xED set-LEDs with ACK
        d0 = done_cnt; e0 = err_cnt;
        send_req(8'hED);
        chk("ed_busy", 32'(bus.tx_busy), 32'd1);
        dev_frame(11, 1'b1, 1'b0, bits, start);
        wait_ready("ed_ready_timeout");
        chk("ed_inhibit_len", 32'(inh_len), 32'd50);
        chk("ed_start_bit", 32'(start), 32'd0);
        chk("ed_data_bits", 32'(bits[7:0]), 32'hED);
        chk("ed_parity", 32'(bits[8]), 32'd1);
        chk("ed_stop", 32'(bits[9]), 32'd1);
        chk("ed_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("ed_err_pulses", 32'(err_cnt - e0), 32'd0);

        // Parity cases; the first frame also carries a 2-cycle clock glitch
        for (int k = 0; k < 3; k++) begin
            d0 = done_cnt;
            send_req(pbyte[k]);
            dev_frame(11, 1'b1, (k == 0), bits, start);
            wait_ready("par_ready_timeout");
            chk("par_data_bits", 32'(bits[7:0]), 32'(pbyte[k]));
            chk("par_parity", 32'(bits[8]), 32'(ppar[k]));
            chk("par_stop", 32'(bits[9]), 32'd1);
            chk("par_done_pulses", 32'(done_cnt - d0), 32'd1);
        end

        // Device never clocks: timeout
        d0 = done_cnt;
        send_req(8'h55);
        n = 0;
        while (!ps2_clk_oe && n < 200) begin @(negedge clk); n++; end
        n = 0;
        while (ps2_clk_oe && n < INH + 20) begin @(negedge clk); n++; end
        n = 0;
        while (!bus.tx_err && n < TO + 100) begin @(negedge clk); n++; end
        chk("to_err_seen", 32'(bus.tx_err), 32'd1);
        chk("to_cycles", 32'(n), 32'(TO - 1));
        chk("to_err_code", 32'(bus.err_code), 32'd1);
        chk("to_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("to_data_oe", 32'(ps2_data_oe), 32'd0);
        @(negedge clk);
        chk("to_ready_next", 32'(bus.tx_ready), 32'd1);
        chk("to_code_hold", 32'(bus.err_code), 32'd1);
        chk("to_no_done", 32'(done_cnt - d0), 32'd0);

`ifdef PS2_TX_RETRY_EN
        // NACK twice, then ACK on the third attempt
        d0 = done_cnt; e0 = err_cnt; p0 = inh_phases;
        send_req(8'hA5);
        dev_frame(11, 1'b0, 1'b0, bits, start);
        chk("retry_busy1", 32'(bus.tx_busy), 32'd1);
        dev_frame(11, 1'b0, 1'b0, bits, start);
        chk("retry_busy2", 32'(bus.tx_busy), 32'd1);
        dev_frame(11, 1'b1, 1'b0, bits, start);
        wait_ready("retry_ready_timeout");
        chk("retry_inhibits", 32'(inh_phases - p0), 32'd3);
        chk("retry_data_bits", 32'(bits[7:0]), 32'hA5);
        chk("retry_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("retry_err_pulses", 32'(err_cnt - e0), 32'd0);
`else
        // NACK: data left high in the ACK slot
        d0 = done_cnt; e0 = err_cnt;
        send_req(8'hA5);
        dev_frame(11, 1'b0, 1'b0, bits, start);
        wait_ready("nack_ready_timeout");
        chk("nack_err_pulses", 32'(err_cnt - e0), 32'd1);
        chk("nack_err_code", 32'(last_err_code), 32'd2);
        chk("nack_no_done", 32'(done_cnt - d0), 32'd0);
        chk("nack_code_hold", 32'(bus.err_code), 32'd2);
`endif

        // Reset in the middle of SEND after edge 4 (0x35 bit3 = 0, so data is pulled low)
        d0 = done_cnt; e0 = err_cnt;
        send_req(8'h35);
        dev_frame(4, 1'b1, 1'b0, bits, start);
        chk("mid_data_oe", 32'(ps2_data_oe), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("mid_rst_data_oe", 32'(ps2_data_oe), 32'd0);
        chk("mid_rst_ready", 32'(bus.tx_ready), 32'd1);
        chk("mid_rst_busy", 32'(bus.tx_busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid_no_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        chk("never_both_pulses", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
